// File: rtl/r2sdf_stage_ctrl_if.sv
// Handshake and butterfly-control bundle between an SDF stage controller and its datapath.
// The master side is the controller; R2_CTRL_FRAME_CNT_EN adds the frame counter.
interface r2sdf_stage_ctrl_if;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] bf_state;
  logic [1:0] bf_wn;
  logic       sr_shift;
  logic       out_valid;
  logic       busy;
`ifdef R2_CTRL_FRAME_CNT_EN
  logic [7:0] frame_cnt;
`endif

  modport master (
    input  in_valid,
    output in_ready, bf_state, bf_wn, sr_shift, out_valid, busy
`ifdef R2_CTRL_FRAME_CNT_EN
    , output frame_cnt
`endif
  );

  modport slave (
    output in_valid,
    input  in_ready, bf_state, bf_wn, sr_shift, out_valid, busy
`ifdef R2_CTRL_FRAME_CNT_EN
    , input frame_cnt
`endif
  );
endinterface

// File: rtl/r2sdf_stage_ctrl.sv
// Radix-2 SDF stage sequencer: outputs combinational from st/cnt/in_valid, first out_valid on beat DELAY+1.
// in_ready drops only for the DELAY-cycle SECOND drain; R2_CTRL_FRAME_CNT_EN adds an 8-bit frame_cnt.
module r2sdf_stage_ctrl #(
  parameter int DELAY = 16
) (
  input  logic               clk,
  input  logic               rst,
  r2sdf_stage_ctrl_if.master bus
);

  localparam int CW = (DELAY > 1) ? $clog2(DELAY) : 1;
  localparam logic [CW-1:0] LAST = CW'(DELAY - 1);

  // Encoding chosen so each state value equals its bf_state code.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_FIRST   = 2'b01,
    ST_SECOND  = 2'b10,
    ST_WAITING = 2'b11
  } st_e;

  if (DELAY < 1 || DELAY > 16 || (DELAY & (DELAY - 1)) != 0) begin : g_bad_delay
    $error("r2sdf_stage_ctrl: DELAY must be a power of 2 in 1..16");
  end

  st_e           r_st;
  logic [CW-1:0] r_cnt;

  st_e           w_st_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic [1:0]    w_bf_state;
  logic          w_sr_shift;
  logic          w_out_valid;
  logic          w_in_ready;
  logic          w_beat;
  logic          w_last;

  assign w_in_ready = (r_st != ST_SECOND);
  assign w_beat     = w_in_ready & bus.in_valid;
  assign w_last     = (r_cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_st  <= ST_IDLE;
      r_cnt <= '0;
    end else begin
      r_st  <= w_st_nxt;
      r_cnt <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_st_nxt    = r_st;
    w_cnt_nxt   = r_cnt;
    w_bf_state  = ST_IDLE;
    w_sr_shift  = 1'b0;
    w_out_valid = 1'b0;

    unique case (r_st)
      ST_IDLE: begin
        // An idle accept is sample 0 of the WAITING phase, so frames run back-to-back.
        if (w_beat) begin
          w_bf_state = ST_WAITING;
          w_sr_shift = 1'b1;
          if (DELAY == 1) begin
            w_st_nxt  = ST_FIRST;
            w_cnt_nxt = '0;
          end else begin
            w_st_nxt  = ST_WAITING;
            w_cnt_nxt = CW'(1);
          end
        end
      end

      ST_WAITING: begin
        if (w_beat) begin
          w_bf_state = ST_WAITING;
          w_sr_shift = 1'b1;
          if (w_last) begin
            w_st_nxt  = ST_FIRST;
            w_cnt_nxt = '0;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
      end

      ST_FIRST: begin
        if (w_beat) begin
          w_bf_state  = ST_FIRST;
          w_sr_shift  = 1'b1;
          w_out_valid = 1'b1;
          if (w_last) begin
            w_st_nxt  = ST_SECOND;
            w_cnt_nxt = '0;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
      end

      ST_SECOND: begin
        w_bf_state  = ST_SECOND;
        w_sr_shift  = 1'b1;
        w_out_valid = 1'b1;
        if (w_last) begin
          w_st_nxt  = ST_IDLE;
          w_cnt_nxt = '0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end

      default: begin
        w_st_nxt  = ST_IDLE;
        w_cnt_nxt = '0;
      end
    endcase
  end

  // floor(2*cnt/DELAY) is just the counter MSB; it stays 0 for DELAY=1.
  assign bus.bf_wn     = (r_st == ST_SECOND) ? {1'b0, r_cnt[CW-1]} : 2'b00;
  assign bus.in_ready  = w_in_ready;
  assign bus.bf_state  = w_bf_state;
  assign bus.sr_shift  = w_sr_shift;
  assign bus.out_valid = w_out_valid;
  assign bus.busy      = (r_st != ST_IDLE);

`ifdef R2_CTRL_FRAME_CNT_EN
  logic [7:0] r_frame_cnt;
  logic       w_frame_done;

  assign w_frame_done = (r_st == ST_SECOND) && w_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame_cnt <= '0;
    end else if (w_frame_done) begin
      r_frame_cnt <= r_frame_cnt + 8'd1;
    end
  end

  assign bus.frame_cnt = r_frame_cnt;
`endif

endmodule

// File: tb/tb_r2sdf_stage_ctrl.sv
// Bench for r2sdf_stage_ctrl: DELAY=4 and DELAY=1 instances share stimulus.
// Vector table, hand sequences, then random stimulus against a frame-position model.
module tb_r2sdf_stage_ctrl;

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_FIRST = 2'b01;
  localparam logic [1:0] S_SECOND = 2'b10;
  localparam logic [1:0] S_WAIT = 2'b11;

  logic clk = 1'b0;
  logic rst;
  logic vld;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  r2sdf_stage_ctrl_if u_if4 ();
  r2sdf_stage_ctrl_if u_if1 ();

  assign u_if4.in_valid = vld;
  assign u_if1.in_valid = vld;

  r2sdf_stage_ctrl #(.DELAY(4)) u_dut4 (.clk(clk), .rst(rst), .bus(u_if4));
  r2sdf_stage_ctrl #(.DELAY(1)) u_dut1 (.clk(clk), .rst(rst), .bus(u_if1));

  typedef struct {
    logic       vld;
    logic [1:0] st;
    logic       rdy;
    logic       ov;
    logic [1:0] wn;
    logic       sr;
    logic       busy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic v, input logic [1:0] st, input logic rdy,
                              input logic ov, input logic [1:0] wn, input logic sr,
                              input logic busy);
    vec_t r;
    r.vld = v; r.st = st; r.rdy = rdy; r.ov = ov; r.wn = wn; r.sr = sr; r.busy = busy;
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Drive inputs just after the edge, then settle to the falling edge for sampling.
  task automatic drive(input logic r, input logic v);
    @(posedge clk);
    #2;
    rst = r;
    vld = v;
    #3;
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    vld = 1'b0;
    #3;
  endtask

  task automatic chk4(input string tag, input vec_t e);
    chk({tag, ".bf_state4"}, int'(u_if4.bf_state), int'(e.st));
    chk({tag, ".in_ready4"}, int'(u_if4.in_ready), int'(e.rdy));
    chk({tag, ".out_valid4"}, int'(u_if4.out_valid), int'(e.ov));
    chk({tag, ".bf_wn4"}, int'(u_if4.bf_wn), int'(e.wn));
    chk({tag, ".sr_shift4"}, int'(u_if4.sr_shift), int'(e.sr));
    chk({tag, ".busy4"}, int'(u_if4.busy), int'(e.busy));
  endtask

  task automatic chk1(input string tag, input vec_t e);
    chk({tag, ".bf_state1"}, int'(u_if1.bf_state), int'(e.st));
    chk({tag, ".in_ready1"}, int'(u_if1.in_ready), int'(e.rdy));
    chk({tag, ".out_valid1"}, int'(u_if1.out_valid), int'(e.ov));
    chk({tag, ".bf_wn1"}, int'(u_if1.bf_wn), int'(e.wn));
    chk({tag, ".sr_shift1"}, int'(u_if1.sr_shift), int'(e.sr));
    chk({tag, ".busy1"}, int'(u_if1.busy), int'(e.busy));
  endtask

  // Model: pos = steps taken in the current frame; [0,D) wait, [D,2D) first, [2D,3D) second.
  function automatic vec_t model_out(input int d, input int pos, input logic v);
    vec_t e;
    e = mk(v, S_IDLE, 1'b1, 1'b0, 2'd0, 1'b0, pos != 0);
    if (pos >= 2 * d) begin
      e.st = S_SECOND; e.rdy = 1'b0; e.ov = 1'b1; e.sr = 1'b1;
      e.wn = 2'((2 * (pos - 2 * d)) / d);
    end else if (v) begin
      e.st = (pos < d) ? S_WAIT : S_FIRST;
      e.ov = (pos >= d);
      e.sr = 1'b1;
    end
    return e;
  endfunction

  function automatic int model_next(input int d, input int pos, input logic r, input logic v);
    if (r) return 0;
    if (pos >= 2 * d || v) return (pos + 1 == 3 * d) ? 0 : pos + 1;
    return pos;
  endfunction

  task automatic run_rows(input string tag, input int lo, input int hi, output int ov_sum);
    ov_sum = 0;
    for (int i = lo; i <= hi; i++) begin
      drive(1'b0, tbl[i].vld);
      chk4($sformatf("%s[%0d]", tag, i), tbl[i]);
      ov_sum += int'(u_if4.out_valid);
    end
  endtask

  initial begin
    int ov_sum;
    int beats;
    int pos4;
    int pos1;
    int fc4;
    int fc1;
    logic r;
    logic v;
    vec_t e;

    rst = 1'b1;
    vld = 1'b0;

    // Rows 0..13: one clean frame; rows 14..28: frame with a 2-cycle stall at FIRST cnt=1.
    tbl.push_back(mk(1'b0, S_IDLE, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, S_WAIT, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(1'b1, S_WAIT, 1'b1, 1'b0, 2'd0, 1'b1, 1'b1));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(1'b1, S_FIRST, 1'b1, 1'b1, 2'd0, 1'b1, 1'b1));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(1'b1, S_SECOND, 1'b0, 1'b1, 2'(i / 2), 1'b1, 1'b1));
    tbl.push_back(mk(1'b0, S_IDLE, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, S_WAIT, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(1'b1, S_WAIT, 1'b1, 1'b0, 2'd0, 1'b1, 1'b1));
    tbl.push_back(mk(1'b1, S_FIRST, 1'b1, 1'b1, 2'd0, 1'b1, 1'b1));
    for (int i = 0; i < 2; i++) tbl.push_back(mk(1'b0, S_IDLE, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(1'b1, S_FIRST, 1'b1, 1'b1, 2'd0, 1'b1, 1'b1));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(1'b0, S_SECOND, 1'b0, 1'b1, 2'(i / 2), 1'b1, 1'b1));
    tbl.push_back(mk(1'b0, S_IDLE, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0));

    do_reset();
    run_rows("frame", 0, 13, ov_sum);
    chk("frame.outputs", ov_sum, 8);
    run_rows("stall", 14, 28, ov_sum);
    chk("stall.outputs", ov_sum, 8);

    // Continuous input for three frames: 12-cycle period, SECOND beats ignored.
    do_reset();
    ov_sum = 0;
    beats = 0;
    for (int c = 0; c < 36; c++) begin
      drive(1'b0, 1'b1);
      chk($sformatf("cont.state[%0d]", c), int'(u_if4.bf_state),
          (c % 12 < 4) ? int'(S_WAIT) : (c % 12 < 8) ? int'(S_FIRST) : int'(S_SECOND));
      ov_sum += int'(u_if4.out_valid);
      beats += int'(u_if4.in_ready & vld);
    end
    chk("cont.outputs", ov_sum, 24);
    chk("cont.beats", beats, 24);

    // Reset pulsed in SECOND cnt=2, then a clean frame must follow.
    do_reset();
    for (int c = 0; c < 10; c++) drive(1'b0, 1'b1);
    drive(1'b1, 1'b1);
    chk("rstmid.state_before", int'(u_if4.bf_state), int'(S_SECOND));
    chk("rstmid.wn_before", int'(u_if4.bf_wn), 1);
    drive(1'b0, 1'b0);
    chk("rstmid.state", int'(u_if4.bf_state), int'(S_IDLE));
    chk("rstmid.busy", int'(u_if4.busy), 0);
    chk("rstmid.out_valid", int'(u_if4.out_valid), 0);
    run_rows("rstmid.frame", 1, 13, ov_sum);
    chk("rstmid.outputs", ov_sum, 8);

    // DELAY=1: W,F,S repeating.
    do_reset();
    for (int c = 0; c < 9; c++) begin
      drive(1'b0, 1'b1);
      case (c % 3)
        0:       e = mk(1'b1, S_WAIT, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0);
        1:       e = mk(1'b1, S_FIRST, 1'b1, 1'b1, 2'd0, 1'b1, 1'b1);
        default: e = mk(1'b1, S_SECOND, 1'b0, 1'b1, 2'd0, 1'b1, 1'b1);
      endcase
      chk1($sformatf("d1[%0d]", c), e);
    end

`ifdef R2_CTRL_FRAME_CNT_EN
    do_reset();
    chk("fc.reset", int'(u_if4.frame_cnt), 0);
    for (int c = 0; c <= 257 * 12; c++) begin
      drive(1'b0, 1'b1);
      if (c > 0 && c % 12 == 0) chk($sformatf("fc[%0d]", c / 12), int'(u_if4.frame_cnt), (c / 12) % 256);
    end
    do_reset();
    chk("fc.cleared", int'(u_if4.frame_cnt), 0);
`endif

    // Random stimulus with occasional resets against the model.
    do_reset();
    pos4 = 0;
    pos1 = 0;
    fc4 = 0;
    fc1 = 0;
    for (int c = 0; c < 3000; c++) begin
      r = ($urandom_range(0, 199) == 0);
      v = ($urandom_range(0, 3) != 0);
      drive(r, v);
      chk4("rand", model_out(4, pos4, v));
      chk1("rand", model_out(1, pos1, v));
`ifdef R2_CTRL_FRAME_CNT_EN
      chk("rand.frame_cnt4", int'(u_if4.frame_cnt), fc4);
      chk("rand.frame_cnt1", int'(u_if1.frame_cnt), fc1);
`endif
      if (r) begin
        fc4 = 0;
        fc1 = 0;
      end else begin
        if (pos4 == 11) fc4 = (fc4 + 1) % 256;
        if (pos1 == 2) fc1 = (fc1 + 1) % 256;
      end
      pos4 = model_next(4, pos4, r, v);
      pos1 = model_next(1, pos1, r, v);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
